rx_uart_byte: RTL and testbench
===============================

RX_UART_BYTE -- requirements
Module: rx_uart_byte

Interface
REQ-001 The block SHALL have parameter CLOCK, default 10_000_000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 1_000_000, line bit rate in bit/s.
REQ-003 The block SHALL have parameter PARITY, default "NO", legal values "NO" / "ODD" / "EVEN".
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port rx, input, 1, asynchronous UART line, idle high.
REQ-007 The block SHALL have port rx_data, output, 8, last received byte.
REQ-008 The block SHALL have port rx_done, output, 1, one-cycle pulse marking frame completion.
REQ-009 The block SHALL have port rx_busy, output, 1, high while a frame is being received.
REQ-010 The block SHALL have port parity_err, output, 1, parity mismatch flag for the last frame.
REQ-011 The block SHALL have port frame_err, output, 1, stop bit sampled low for the last frame.

Function
REQ-012 The block SHALL define FACTOR = CLOCK/BAUD (integer division); FACTOR < 4 SHALL be a static elaboration error.
REQ-013 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); rx_s denotes the synchronized value and rx_s_d its one-cycle delay.
REQ-014 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 In IDLE, rx_s_d==1 and rx_s==0 SHALL move the FSM to START, clear the bit-period counter and assert rx_busy on the next cycle.
REQ-016 In START, the sample SHALL occur when the counter reaches FACTOR/2-1; rx_s==1 there means a false start: go to IDLE, deassert rx_busy, no rx_done.
REQ-017 The counter SHALL clear on every sample; every later sample SHALL occur at counter==FACTOR-1.
REQ-018 DATA SHALL take 8 samples, LSB first, into a shift register, then go to PARITY if PARITY!="NO", else to STOP.
REQ-019 PARITY SHALL take one sample; parity_err = (XOR of data ^ sampled bit) != 1 for "ODD" and != 0 for "EVEN"; parity_err SHALL be 0 when PARITY=="NO".
REQ-020 STOP SHALL take one sample; frame_err = ~rx_s at that sample.
REQ-021 On the stop-sample cycle the outputs SHALL update as follows: rx_data, parity_err and frame_err load together on the next edge; rx_done pulses high for exactly one cycle; rx_busy falls on that same edge.
REQ-022 rx_busy and rx_done SHALL never be high in the same cycle.
REQ-023 After a good stop bit the FSM SHALL return to IDLE immediately at mid-stop, so a start edge arriving half a bit later is accepted.
REQ-024 After a low stop bit (frame_err=1) the FSM SHALL enter BREAK and stay there until rx_s==1, then go to IDLE; no start edge is detected in BREAK.
REQ-025 rx_data, parity_err and frame_err SHALL hold their values until the next rx_done, and SHALL be updated even on an errored frame.
REQ-026 The counter width SHALL be clog2(FACTOR); the counter SHALL never wrap past FACTOR-1.

Reset
REQ-027 On reset, outputs SHALL be rx_data=8'h00, rx_done=0, rx_busy=0, parity_err=0, frame_err=0; FSM=IDLE; counters=0; synchronizer flops=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no rx_done; after release, reception SHALL restart only on a fresh falling edge.

Verification (CLOCK=10_000_000, BAUD=1_000_000, FACTOR=10)
REQ-029 PARITY="NO", send 0xA5 at 10 clk/bit -> one rx_done pulse, rx_data=0xA5, both error flags 0, rx_busy high for about 95 cycles.
REQ-030 PARITY="EVEN", send 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1; resend with parity bit 1 -> parity_err=0.
REQ-031 rx low pulse of 3 cycles -> rx_busy high then low, no rx_done.
REQ-032 Send 0x55 with stop bit 0, hold rx low for 30 cycles, then send 0x3C -> first frame: frame_err=1, rx_data=0x55; second frame: rx_data=0x3C, frame_err=0.
REQ-033 Back-to-back frames 0x01, 0xFF, 0x80 with no idle gap -> three rx_done pulses with correct data.
REQ-034 Assert reset during bit 4 of a frame -> no rx_done; all outputs at reset values; the next full frame is received correctly.

Source files
------------

// File: rtl/rx_uart_byte.sv
// rx_uart_byte: oversampling UART receiver with optional parity, false-start rejection and break handling
module rx_uart_byte #(
  parameter int    CLOCK  = 10_000_000,
  parameter int    BAUD   = 1_000_000,
  parameter string PARITY = "NO"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int FACTOR = CLOCK / BAUD;
  localparam int CW = $clog2(FACTOR);
  localparam logic [CW-1:0] HALF = CW'(FACTOR / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(FACTOR - 1);
  localparam bit HAS_PAR = PARITY != "NO";
  localparam bit ODD = PARITY == "ODD";
  if (FACTOR < 4) begin : g_bad_factor
    $error("rx_uart_byte: CLOCK/BAUD must be at least 4");
  end
  if (PARITY != "NO" && PARITY != "ODD" && PARITY != "EVEN") begin : g_bad_parity
    $error("rx_uart_byte: PARITY must be NO, ODD or EVEN");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP, BREAK} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, rx_s_d;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic pbit, sample, start_edge, false_start, stop_smp;
  always_comb begin
    start_edge = state == IDLE && rx_s_d && !rx_s;
    sample = state == START ? cnt == HALF :
             (state == DATA || state == PARITY_BIT || state == STOP) ? cnt == LAST : 1'b0;
    false_start = state == START && sample && rx_s;
    stop_smp = state == STOP && sample;
    state_n = state;
    case (state)
      IDLE:       state_n = start_edge ? START : IDLE;
      START:      state_n = !sample ? START : rx_s ? IDLE : DATA;
      DATA:       state_n = !(sample && bit_cnt == 3'd7) ? DATA : HAS_PAR ? PARITY_BIT : STOP;
      PARITY_BIT: state_n = sample ? STOP : PARITY_BIT;
      STOP:       state_n = !sample ? STOP : rx_s ? IDLE : BREAK;
      BREAK:      state_n = rx_s ? IDLE : BREAK;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // The counter only runs inside a frame and restarts at every sample, so it never passes LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_s_d     <= 1'b1;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      pbit       <= 1'b0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      rx_busy    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_s_d  <= rx_s;
      cnt     <= (state == IDLE || state == BREAK || sample) ? '0 : cnt + CW'(1);
      rx_done <= stop_smp;
      rx_busy <= start_edge ? 1'b1 : (false_start || stop_smp) ? 1'b0 : rx_busy;
      if (state == START) bit_cnt <= '0;
      if (state == DATA && sample) begin
        shift   <= {rx_s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == PARITY_BIT && sample) pbit <= rx_s;
      if (stop_smp) begin
        rx_data    <= shift;
        parity_err <= HAS_PAR && ((^shift ^ pbit) != ODD);
        frame_err  <= ~rx_s;
      end
    end
  end
endmodule

// File: tb/tb_rx_uart_byte.sv
// tb_rx_uart_byte: directed and random frames into NO/EVEN/ODD receivers, checked against a frame-level model
module tb_rx_uart_byte;
  localparam int F = 10;
  typedef struct packed {logic [7:0] d; logic pe; logic fe;} rec_t;
  logic clk = 1'b0, reset = 1'b1, line = 1'b1;
  int sel = 0;
  logic rx_l [3];
  logic [7:0] d [3];
  logic done [3], busy [3], pe [3], fe [3];
  rec_t q [3][$];
  int run [3], last_run [3];
  int ovl = 0, errors = 0, checks = 0;
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < 3; i++) rx_l[i] = (sel == i) ? line : 1'b1;
  rx_uart_byte #(.CLOCK(10_000_000), .BAUD(1_000_000), .PARITY("NO")) dut_n (
    .clk(clk), .reset(reset), .rx(rx_l[0]), .rx_data(d[0]), .rx_done(done[0]),
    .rx_busy(busy[0]), .parity_err(pe[0]), .frame_err(fe[0]));
  rx_uart_byte #(.CLOCK(10_000_000), .BAUD(1_000_000), .PARITY("EVEN")) dut_e (
    .clk(clk), .reset(reset), .rx(rx_l[1]), .rx_data(d[1]), .rx_done(done[1]),
    .rx_busy(busy[1]), .parity_err(pe[1]), .frame_err(fe[1]));
  rx_uart_byte #(.CLOCK(10_000_000), .BAUD(1_000_000), .PARITY("ODD")) dut_o (
    .clk(clk), .reset(reset), .rx(rx_l[2]), .rx_data(d[2]), .rx_done(done[2]),
    .rx_busy(busy[2]), .parity_err(pe[2]), .frame_err(fe[2]));
  initial for (int i = 0; i < 3; i++) begin run[i] = 0; last_run[i] = 0; end
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      if (done[i]) q[i].push_back({d[i], pe[i], fe[i]});
      if (done[i] && busy[i]) ovl++;
      if (busy[i]) run[i]++;
      else if (run[i] != 0) begin
        last_run[i] = run[i];
        run[i] = 0;
      end
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] dt, input int pb, input bit stop);
    line = 1'b0;
    tick(F);
    for (int i = 0; i < 8; i++) begin
      line = dt[i];
      tick(F);
    end
    if (pb >= 0) begin
      line = pb[0];
      tick(F);
    end
    line = stop;
    tick(F);
  endtask
  function automatic rec_t model(input int mode, input logic [7:0] dt, input int pb, input bit stop);
    int ones;
    rec_t r;
    ones = $countones(dt) + ((pb > 0) ? 1 : 0);
    r.d = dt;
    r.pe = (mode == 0) ? 1'b0 : (mode == 1) ? (ones % 2 != 0) : (ones % 2 != 1);
    r.fe = !stop;
    return r;
  endfunction
  task automatic chk_frame(input string tag, input int i, input rec_t exp);
    rec_t r;
    chk({tag, "_count"}, q[i].size(), 1);
    r = (q[i].size() > 0) ? q[i].pop_front() : 'x;
    chk({tag, "_data"}, r.d, exp.d);
    chk({tag, "_perr"}, r.pe, exp.pe);
    chk({tag, "_ferr"}, r.fe, exp.fe);
    q[i].delete();
  endtask
  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++)
      chk(tag, {d[i], done[i], busy[i], pe[i], fe[i]}, 0);
  endtask
  initial begin
    rec_t r;
    logic [7:0] dt;
    int pb, gap;
    bit stop;
    logic [7:0] b2b [3];
    b2b[0] = 8'h01; b2b[1] = 8'hFF; b2b[2] = 8'h80;
    tick(3);
    chk_reset("reset_state");
    reset = 1'b0;
    tick(5);
    sel = 0;
    send(8'hA5, -1, 1'b1);
    tick(F);
    chk_frame("no_a5", 0, model(0, 8'hA5, -1, 1'b1));
    chk("no_a5_busy_len", last_run[0], 95);
    sel = 1;
    send(8'h07, 0, 1'b1);
    tick(F);
    chk_frame("even_07_p0", 1, model(1, 8'h07, 0, 1'b1));
    send(8'h07, 1, 1'b1);
    tick(F);
    chk_frame("even_07_p1", 1, model(1, 8'h07, 1, 1'b1));
    sel = 0;
    line = 1'b0;
    tick(3);
    line = 1'b1;
    tick(2 * F);
    chk("false_start_busy_len", last_run[0], F / 2);
    chk("false_start_no_done", q[0].size(), 0);
    send(8'h55, -1, 1'b0);
    line = 1'b0;
    tick(30);
    line = 1'b1;
    tick(F);
    chk_frame("break_55", 0, model(0, 8'h55, -1, 1'b0));
    send(8'h3C, -1, 1'b1);
    tick(F);
    chk_frame("after_break_3c", 0, model(0, 8'h3C, -1, 1'b1));
    for (int k = 0; k < 3; k++) send(b2b[k], -1, 1'b1);
    tick(F);
    chk("b2b_count", q[0].size(), 3);
    for (int k = 0; k < 3; k++) begin
      r = (q[0].size() > 0) ? q[0].pop_front() : 'x;
      chk("b2b_data", r, model(0, b2b[k], -1, 1'b1));
    end
    q[0].delete();
    line = 1'b0;
    tick(F);
    for (int i = 0; i < 4; i++) begin
      line = 1'(i % 2);
      tick(F);
    end
    tick(F / 2);
    reset = 1'b1;
    line = 1'b1;
    tick(2);
    chk_reset("mid_reset_state");
    reset = 1'b0;
    tick(2 * F);
    chk("mid_reset_no_done", q[0].size(), 0);
    chk("mid_reset_idle", {busy[0], d[0]}, 0);
    send(8'h96, -1, 1'b1);
    tick(F);
    chk_frame("after_reset_96", 0, model(0, 8'h96, -1, 1'b1));
    for (int k = 0; k < 30; k++) begin
      sel = k % 3;
      dt = 8'($urandom);
      pb = (sel == 0) ? -1 : int'($urandom_range(0, 1));
      stop = $urandom_range(0, 3) != 0;
      gap = int'($urandom_range(0, 2)) * F;
      send(dt, pb, stop);
      if (!stop) begin
        line = 1'b0;
        tick(int'($urandom_range(1, 20)));
        line = 1'b1;
        tick(F);
      end else tick(gap);
      chk_frame("rand", sel, model(sel, dt, pb, stop));
    end
    chk("busy_done_overlap", ovl, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
